// File: rtl/pcie_stream_rr_arbiter.sv
// Round-robin packet arbiter: merges NREQ valid/ready streams into one registered
// stream, holding the grant from a packet's first beat through its last beat.
module pcie_stream_rr_arbiter #(
    parameter  int unsigned NREQ = 4,
    parameter  int unsigned DW   = 8,
    localparam int unsigned IW   = $clog2(NREQ)
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [NREQ-1:0]      i_valid,
    output logic [NREQ-1:0]      o_ready,
    input  logic [NREQ*DW-1:0]   i_data,
    input  logic [NREQ-1:0]      i_last,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DW-1:0]        o_data,
    output logic                 o_last,
    output logic [IW-1:0]        o_grant,
    output logic                 o_busy
);

    localparam int unsigned CW = IW + 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]      state_q,  state_d;
    logic [IW-1:0]   grant_q,  grant_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            valid_q,  valid_d;
    logic [DW-1:0]   data_q,   data_d;
    logic            last_q,   last_d;

    logic            out_free;
    logic            owner_valid;
    logic            owner_last;
    logic [DW-1:0]   owner_data;
    logic            beat_acc;
    logic            last_acc;
    logic            arb_en;
    logic [IW-1:0]   ptr_next;
    logic [IW-1:0]   arb_base;
    logic [NREQ-1:0] arb_req;
    logic [CW-1:0]   cand;
    logic            win_found;
    logic [IW-1:0]   win_idx;

    // Select the current owner's beat
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant_q == IW'(k)) begin
                owner_valid = i_valid[k];
                owner_last  = i_last[k];
                owner_data  = i_data[k*DW +: DW];
            end
        end
    end

    // Handshake qualifiers
    always_comb begin
        out_free = !valid_q || i_ready;
        beat_acc = (state_q == ST_LOCKED) && out_free && owner_valid;
        last_acc = beat_acc && owner_last;
        arb_en   = (state_q == ST_IDLE) || last_acc;
        ptr_next = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);
    end

    // Round-robin search; on a finishing packet the owner's consumed valid is masked
    // and the search starts just past it, so it ranks last in this round.
    always_comb begin
        arb_base  = last_acc ? ptr_next : rr_ptr_q;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            arb_req[k] = i_valid[k] && !(last_acc && (grant_q == IW'(k)));
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = CW'(arb_base) + CW'(i);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!win_found && arb_req[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    // Next-state and output-stage logic
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        valid_d  = valid_q;
        data_d   = data_q;
        last_d   = last_q;

        if (arb_en) begin
            if (win_found) begin
                state_d = ST_LOCKED;
                grant_d = win_idx;
            end else begin
                state_d = ST_IDLE;
            end
        end

        if (last_acc) begin
            rr_ptr_d = ptr_next;
        end

        if (out_free) begin
            valid_d = beat_acc;
            if (beat_acc) begin
                data_d = owner_data;
                last_d = owner_last;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            last_q   <= last_d;
        end
    end

    // Only the owner is ready, and only when the output stage can take a beat
    always_comb begin
        for (int unsigned k = 0; k < NREQ; k++) begin
            o_ready[k] = i_reset_n && (state_q == ST_LOCKED) && (grant_q == IW'(k)) && out_free;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_last  = last_q;
    assign o_grant = grant_q;
    assign o_busy  = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_pcie_stream_rr_arbiter.sv
// Scoreboard bench for pcie_stream_rr_arbiter: per-requester beat queues drive the
// inputs, expected beats are queued in grant order and matched at the output.
module tb_pcie_stream_rr_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned IW   = $clog2(NREQ);

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int unsigned   gap;
    } beat_t;

    logic                clk;
    logic                reset_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_last;
    logic                out_valid;
    logic                out_ready;
    logic [DW-1:0]       out_data;
    logic                out_last;
    logic [IW-1:0]       grant;
    logic                busy;

    beat_t       src_q [NREQ][$];
    int unsigned gap_cnt [NREQ];
    logic [DW:0] exp_q [$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned fire_cnt = 0;

    pcie_stream_rr_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_valid   (req_valid),
        .o_ready   (req_ready),
        .i_data    (req_data),
        .i_last    (req_last),
        .o_valid   (out_valid),
        .i_ready   (out_ready),
        .o_data    (out_data),
        .o_last    (out_last),
        .o_grant   (grant),
        .o_busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < NREQ; k++) begin
            if (src_q[k].size() != 0 && gap_cnt[k] == 0) begin
                req_valid[k]           = 1'b1;
                req_data[k*DW +: DW]   = src_q[k][0].data;
                req_last[k]            = src_q[k][0].last;
            end else begin
                req_valid[k]           = 1'b0;
                req_data[k*DW +: DW]   = '0;
                req_last[k]            = 1'b0;
            end
        end
    endtask

    // One clock: sample handshakes at negedge, advance requester queues after posedge
    task automatic tick();
        logic [NREQ-1:0] acc;
        logic [DW:0]     exp_beat;
        beat_t           popped;
        @(negedge clk);
        acc = req_valid & req_ready;
        if (out_valid && out_ready) begin
            fire_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_beat", 32'(out_valid), 32'd0);
            end else begin
                exp_beat = exp_q.pop_front();
                check_eq("beat_data", 32'(out_data), 32'(exp_beat[DW-1:0]));
                check_eq("beat_last", 32'(out_last), 32'(exp_beat[DW]));
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NREQ; k++) begin
            if (acc[k]) begin
                popped = src_q[k].pop_front();
                if (src_q[k].size() != 0) gap_cnt[k] = src_q[k][0].gap;
            end else if (gap_cnt[k] != 0) begin
                gap_cnt[k] = gap_cnt[k] - 1;
            end
        end
        drive_inputs();
    endtask

    task automatic push_pkt(input int src, input logic [DW-1:0] base, input logic [DW-1:0] step,
                            input int nbeats, input int gap_at, input int unsigned gap_len);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.data = base + DW'(i) * step;
            b.last = (i == nbeats - 1);
            b.gap  = (i == gap_at) ? gap_len : 0;
            if (src_q[src].size() == 0) gap_cnt[src] = b.gap;
            src_q[src].push_back(b);
            exp_q.push_back({b.last, b.data});
        end
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            src_q[k].delete();
            gap_cnt[k] = 0;
        end
        drive_inputs();
        tick();
        tick();
        exp_q.delete();
        reset_n = 1'b1;
    endtask

    initial begin
        int unsigned f0;
        bit          seen;
        reset_n   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        out_ready = 1'b1;
        for (int k = 0; k < NREQ; k++) gap_cnt[k] = 0;
        @(posedge clk);
        #1;
        do_reset();

        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data",  32'(out_data),  32'd0);
        check_eq("rst_last",  32'(out_last),  32'd0);
        check_eq("rst_grant", 32'(grant),     32'd0);
        check_eq("rst_busy",  32'(busy),      32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);

        // Single requester, 3-beat packet
        push_pkt(2, 8'h11, 8'h11, 3, -1, 0);
        drive_inputs();
        #1;
        check_eq("t1_idle_ready", 32'(req_ready), 32'd0);
        tick();
        check_eq("t1_grant",     32'(grant),     32'd2);
        check_eq("t1_busy",      32'(busy),      32'd1);
        check_eq("t1_lat_valid", 32'(out_valid), 32'd0);
        check_eq("t1_ready",     32'(req_ready), 32'b0100);
        tick();
        check_eq("t1_first_valid", 32'(out_valid), 32'd1);
        check_eq("t1_first_data",  32'(out_data),  32'h11);
        tick();
        tick();
        check_eq("t1_busy_drop", 32'(busy),      32'd0);
        check_eq("t1_end_valid", 32'(out_valid), 32'd1);
        check_eq("t1_end_data",  32'(out_data),  32'h33);
        check_eq("t1_end_last",  32'(out_last),  32'd1);
        tick();
        check_eq("t1_idle_valid", 32'(out_valid), 32'd0);
        check_eq("t1_drain", 32'(exp_q.size()), 32'd0);

        // Wrap-around: pointer at 3, requests from 0 and 3
        push_pkt(3, 8'h31, 8'h01, 1, -1, 0);
        push_pkt(0, 8'h01, 8'h01, 1, -1, 0);
        drive_inputs();
        tick();
        check_eq("wrap_first", 32'(grant), 32'd3);
        tick();
        check_eq("wrap_second",      32'(grant), 32'd0);
        check_eq("wrap_second_busy", 32'(busy),  32'd1);
        tick();
        check_eq("wrap_release", 32'(busy), 32'd0);
        drain("wrap_drain");

        // Fairness: all four requesters with two 2-beat packets each
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < NREQ; s++)
                push_pkt(s, 8'(s * 16 + r * 2), 8'h01, 2, -1, 0);
        drive_inputs();
        f0 = 0;
        for (int t = 1; t <= 18; t++) begin
            tick();
            if (t == 2) f0 = fire_cnt;
            if ((t % 2) == 1 && t <= 15)
                check_eq("fair_grant", 32'(grant), 32'(((t - 1) / 2) % NREQ));
            if (t <= 16) check_eq("fair_busy", 32'(busy), 32'd1);
            if (t == 17) check_eq("fair_release", 32'(busy), 32'd0);
        end
        check_eq("fair_throughput", 32'(fire_cnt - f0), 32'd16);
        drain("fair_drain");

        // Backpressure: downstream stalls for 3 cycles mid-packet
        push_pkt(1, 8'hB0, 8'h01, 4, -1, 0);
        drive_inputs();
        tick();
        check_eq("bp_grant", 32'(grant), 32'd1);
        tick();
        tick();
        out_ready = 1'b0;
        #1;
        check_eq("bp_ready_low", 32'(req_ready), 32'd0);
        check_eq("bp_hold_data", 32'(out_data),  32'hB1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bp_stall_valid", 32'(out_valid), 32'd1);
            check_eq("bp_stall_data",  32'(out_data),  32'hB1);
            check_eq("bp_stall_last",  32'(out_last),  32'd0);
            check_eq("bp_stall_ready", 32'(req_ready), 32'd0);
        end
        out_ready = 1'b1;
        drain("bp_drain");
        tick();
        tick();

        // No interleaving: req 0 bubbles mid-packet while req 1 waits
        push_pkt(0, 8'h40, 8'h01, 4, 2, 2);
        push_pkt(1, 8'h50, 8'h01, 2, -1, 0);
        drive_inputs();
        seen = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (src_q[0].size() != 0) begin
                check_eq("noint_rdy1_low", 32'(req_ready[1]), 32'd0);
            end else if (!seen) begin
                seen = 1'b1;
                check_eq("noint_rdy1_hand", 32'(req_ready[1]), 32'd1);
                check_eq("noint_grant1",    32'(grant),        32'd1);
            end
        end
        drain("noint_drain");

        // Mid-packet reset during beat 2 of 4
        push_pkt(2, 8'hC0, 8'h01, 4, -1, 0);
        drive_inputs();
        tick();
        check_eq("mrst_grant", 32'(grant), 32'd2);
        tick();
        reset_n = 1'b0;
        #1;
        check_eq("mrst_ready", 32'(req_ready), 32'd0);
        tick();
        check_eq("mrst_valid", 32'(out_valid), 32'd0);
        check_eq("mrst_data",  32'(out_data),  32'd0);
        check_eq("mrst_last",  32'(out_last),  32'd0);
        check_eq("mrst_grant0", 32'(grant),    32'd0);
        check_eq("mrst_busy",  32'(busy),      32'd0);
        check_eq("mrst_partial", 32'(exp_q.size()), 32'd3);
        reset_n = 1'b1;
        src_q[2].delete();
        gap_cnt[2] = 0;
        exp_q.delete();
        drive_inputs();
        tick();
        check_eq("mrst_no_fwd", 32'(out_valid), 32'd0);
        push_pkt(0, 8'hD0, 8'h01, 1, -1, 0);
        push_pkt(2, 8'hE0, 8'h01, 1, -1, 0);
        drive_inputs();
        tick();
        check_eq("mrst_rearb", 32'(grant), 32'd0);
        drain("mrst_drain");
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
